led_seq_ctrl: RTL and testbench

//   MMIO-programmable sequencer that owns the write port (we/wdata) of the 16-bit LED register.
//   CPU stores to four word registers select a mode: STOP, DIRECT, BLINK or SHIFT.
//   The block then issues single-cycle LED write pulses, either on CPU demand or from a period timer.

---
 rtl/led_pkg.sv | 29 ++
 rtl/led_tick_timer.sv | 28 ++
 rtl/led_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_led_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: mode codes, FSM state encodings
// and MMIO word offsets.
package led_pkg;

    localparam int LED_W_DFLT = 16;
    localparam int CNT_W_DFLT = 32;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_DIRECT = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_SHIFT  = 2'd3
    } mode_e;

    // Encoding is visible to software through STATUS[18:16].
    typedef enum logic [2:0] {
        ST_STOP      = 3'd0,
        ST_DIRECT    = 3'd1,
        ST_BLINK_ON  = 3'd2,
        ST_BLINK_OFF = 3'd3,
        ST_SHIFT     = 3'd4
    } state_e;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PATTERN = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

endpackage

// File: rtl/led_tick_timer.sv
// Free-running period timer: counts 0..PERIOD while enabled and flags the
// cycle in which the count reaches PERIOD, giving one expiry per PERIOD+1 cycles.
module led_tick_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;

    assign expire_o = en_i && (cnt_q == period_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= expire_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// MMIO-programmable LED sequencer: register file, mode FSM and the registered
// write port that is the only driver of the LED register.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int LED_W = LED_W_DFLT,
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_we_i,
    input  logic [1:0]       bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic [31:0]      bus_rdata_o,
    output logic             led_we_o,
    output logic [LED_W-1:0] led_wdata_o
);

    state_e           state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [LED_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [LED_W-1:0] shadow_q, shadow_d;
    logic             led_we_q, led_we_d;
    logic [LED_W-1:0] led_wdata_q, led_wdata_d;

    logic             tmr_en, tmr_clr, expire;
    logic             bus_wr, wr_en;
    logic [LED_W-1:0] wr_val;

    function automatic logic [LED_W-1:0] rot1(input logic [LED_W-1:0] v, input logic right);
        return right ? {v[0], v[LED_W-1:1]} : {v[LED_W-2:0], v[LED_W-1]};
    endfunction

    assign tmr_en = (state_q == ST_BLINK_ON) || (state_q == ST_BLINK_OFF) || (state_q == ST_SHIFT);
    // STATUS is read-only, so a store to it neither counts as a write nor masks an expiry.
    assign bus_wr = bus_we_i && (bus_addr_i != REG_STATUS);

    led_tick_timer #(.CNT_W(CNT_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en_i     (tmr_en),
        .clr_i    (tmr_clr),
        .period_i (period_q),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOP;
            ctrl_q      <= '0;
            pattern_q   <= '0;
            period_q    <= '0;
            shadow_q    <= '0;
            led_we_q    <= 1'b0;
            led_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            pattern_q   <= pattern_d;
            period_q    <= period_d;
            shadow_q    <= shadow_d;
            led_we_q    <= led_we_d;
            led_wdata_q <= led_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        pattern_d   = pattern_q;
        period_d    = period_q;
        shadow_d    = shadow_q;
        led_we_d    = 1'b0;
        led_wdata_d = led_wdata_q;
        tmr_clr     = 1'b0;
        wr_en       = 1'b0;
        wr_val      = '0;

        // A bus store always wins over a coincident timer expiry.
        if (bus_wr) begin
            case (bus_addr_i)
                REG_CTRL: begin
                    ctrl_d = bus_wdata_i[2:0];
                    if (bus_wdata_i[1:0] != ctrl_q[1:0]) begin
                        tmr_clr = 1'b1;
                        wr_en   = 1'b1;
                        case (mode_e'(bus_wdata_i[1:0]))
                            MODE_DIRECT: begin state_d = ST_DIRECT;   wr_val = pattern_q; end
                            MODE_BLINK:  begin state_d = ST_BLINK_ON; wr_val = pattern_q; end
                            MODE_SHIFT:  begin state_d = ST_SHIFT;    wr_val = pattern_q; end
                            default:     begin state_d = ST_STOP;     wr_val = '0;        end
                        endcase
                    end
                end
                REG_PATTERN: begin
                    pattern_d = bus_wdata_i[LED_W-1:0];
                    case (state_q)
                        ST_DIRECT: begin
                            wr_en  = 1'b1;
                            wr_val = bus_wdata_i[LED_W-1:0];
                        end
                        ST_BLINK_ON, ST_SHIFT: begin
                            wr_en   = 1'b1;
                            wr_val  = bus_wdata_i[LED_W-1:0];
                            tmr_clr = 1'b1;
                        end
                        default: ;
                    endcase
                end
                REG_PERIOD: begin
                    period_d = bus_wdata_i[CNT_W-1:0];
                    tmr_clr  = 1'b1;
                end
                default: ;
            endcase
        end else if (expire) begin
            case (state_q)
                ST_BLINK_ON:  begin state_d = ST_BLINK_OFF; wr_en = 1'b1; wr_val = '0;        end
                ST_BLINK_OFF: begin state_d = ST_BLINK_ON;  wr_en = 1'b1; wr_val = pattern_q; end
                ST_SHIFT:     begin wr_en = 1'b1; wr_val = rot1(shadow_q, ctrl_q[2]);         end
                default: ;
            endcase
        end

        // shadow tracks every value pushed to the LED register.
        if (wr_en) begin
            led_we_d    = 1'b1;
            led_wdata_d = wr_val;
            shadow_d    = wr_val;
        end
    end

    always_comb begin
        bus_rdata_o = '0;
        case (bus_addr_i)
            REG_CTRL:    bus_rdata_o = 32'(ctrl_q);
            REG_PATTERN: bus_rdata_o = 32'(pattern_q);
            REG_PERIOD:  bus_rdata_o = 32'(period_q);
            default:     bus_rdata_o = 32'({state_q, shadow_q});
        endcase
    end

    assign led_we_o    = led_we_q;
    assign led_wdata_o = led_wdata_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: register/DIRECT vector table plus
// timed BLINK, SHIFT, collision and reset sequences checked by a pulse scoreboard.
module tb_led_seq_ctrl;
    import led_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = REG_STATUS;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        led_we;
    logic [15:0] led_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        bit          exp_we;
        logic [15:0] exp_wdata;
        logic [31:0] exp_status;
        logic [31:0] exp_ctrl;
    } vec_t;
    vec_t vecs[11];

    led_seq_ctrl #(.LED_W(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_we_i    (bus_we),
        .bus_addr_i  (bus_addr),
        .bus_wdata_i (bus_wdata),
        .bus_rdata_o (bus_rdata),
        .led_we_o    (led_we),
        .led_wdata_o (led_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_wr(input int c, input logic [15:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Store is captured at the end of the current cycle.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_we = 1'b0; bus_addr = REG_STATUS; bus_wdata = '0;
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
        bus_addr = a; #1;
        check_val(nm, bus_rdata, exp);
        bus_addr = REG_STATUS;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: every led_we must match the head entry in cycle and data.
    always @(negedge clk) begin
        if (!rst) begin
            if (led_we) begin
                if (exp_q.size() == 0) begin
                    check_val("led_we_unexpected", 32'(led_we), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("led_we_cycle", cyc, mon_e.cyc);
                    check_val("led_wdata", 32'(led_wdata), 32'(mon_e.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                check_val("led_we_missing", 32'(led_we), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        //           addr         wdata          we    wdata     status          ctrl
        vecs[0]  = '{REG_CTRL,    32'h0000_0001, 1'b1, 16'h0000, 32'h0001_0000, 32'd1};
        vecs[1]  = '{REG_PATTERN, 32'h0000_A5A5, 1'b1, 16'hA5A5, 32'h0001_A5A5, 32'd1};
        vecs[2]  = '{REG_STATUS,  32'hFFFF_FFFF, 1'b0, 16'h0000, 32'h0001_A5A5, 32'd1};
        vecs[3]  = '{REG_CTRL,    32'hFFFF_FFFD, 1'b0, 16'h0000, 32'h0001_A5A5, 32'd5};
        vecs[4]  = '{REG_PATTERN, 32'h0001_1234, 1'b1, 16'h1234, 32'h0001_1234, 32'd5};
        vecs[5]  = '{REG_CTRL,    32'h0000_0000, 1'b1, 16'h0000, 32'h0000_0000, 32'd0};
        vecs[6]  = '{REG_PATTERN, 32'h0000_FFFF, 1'b0, 16'h0000, 32'h0000_0000, 32'd0};
        vecs[7]  = '{REG_CTRL,    32'h0000_0000, 1'b0, 16'h0000, 32'h0000_0000, 32'd0};
        vecs[8]  = '{REG_CTRL,    32'h0000_0001, 1'b1, 16'hFFFF, 32'h0001_FFFF, 32'd1};
        vecs[9]  = '{REG_PERIOD,  32'h0000_0007, 1'b0, 16'h0000, 32'h0001_FFFF, 32'd1};
        vecs[10] = '{REG_CTRL,    32'h0000_0004, 1'b1, 16'h0000, 32'h0000_0000, 32'd4};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_led_we", 32'(led_we), 32'd0);
        check_val("reset_led_wdata", 32'(led_wdata), 32'd0);
        read_chk(REG_STATUS, 32'h0, "reset_status");
        @(posedge clk); #1;
        rst = 1'b0;
        read_chk(REG_CTRL, 32'h0, "reset_ctrl");
        read_chk(REG_PATTERN, 32'h0, "reset_pattern");
        read_chk(REG_PERIOD, 32'h0, "reset_period");
        repeat (2) begin @(posedge clk); #1; end

        // Register file / DIRECT / STOP vectors
        for (int i = 0; i < 11; i++) begin
            c = cyc;
            bus_write(vecs[i].addr, vecs[i].wdata);
            if (vecs[i].exp_we) expect_wr(c + 1, vecs[i].exp_wdata);
            repeat (2) begin @(posedge clk); #1; end
            read_chk(REG_STATUS, vecs[i].exp_status, $sformatf("vec%0d_status", i));
            read_chk(REG_CTRL, vecs[i].exp_ctrl, $sformatf("vec%0d_ctrl", i));
        end
        read_chk(REG_PERIOD, 32'd7, "period_readback");

        // BLINK, PERIOD=3: toggles every 4 cycles
        bus_write(REG_PERIOD, 32'd3);
        bus_write(REG_PATTERN, 32'h0000_00FF);
        c = cyc;
        bus_write(REG_CTRL, 32'd2);
        expect_wr(c + 1, 16'h00FF);
        expect_wr(c + 5, 16'h0000);
        expect_wr(c + 9, 16'h00FF);
        expect_wr(c + 13, 16'h0000);
        read_chk(REG_STATUS, 32'h0002_00FF, "blink_on_status");
        wait_cyc(c + 7);
        read_chk(REG_STATUS, 32'h0003_0000, "blink_off_status");
        wait_cyc(c + 15);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 16, 16'h0000);
        repeat (3) begin @(posedge clk); #1; end

        // Collision: PATTERN store in the same cycle as a BLINK_ON expiry
        c = cyc;
        bus_write(REG_CTRL, 32'd2);
        expect_wr(c + 1, 16'h00FF);
        wait_cyc(c + 4);
        bus_write(REG_PATTERN, 32'h0000_0F0F);
        expect_wr(c + 5, 16'h0F0F);
        expect_wr(c + 9, 16'h0000);
        expect_wr(c + 13, 16'h0F0F);
        wait_cyc(c + 14);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 15, 16'h0000);
        repeat (3) begin @(posedge clk); #1; end

        // PERIOD lowered below the running count
        bus_write(REG_PERIOD, 32'd7);
        c = cyc;
        bus_write(REG_CTRL, 32'd2);
        expect_wr(c + 1, 16'h0F0F);
        wait_cyc(c + 6);
        bus_write(REG_PERIOD, 32'd2);
        expect_wr(c + 10, 16'h0000);
        expect_wr(c + 13, 16'h0F0F);
        wait_cyc(c + 14);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 15, 16'h0000);
        repeat (3) begin @(posedge clk); #1; end

        // SHIFT left, PERIOD=0
        bus_write(REG_PATTERN, 32'h0000_8001);
        bus_write(REG_PERIOD, 32'd0);
        c = cyc;
        bus_write(REG_CTRL, 32'd3);
        expect_wr(c + 1, 16'h8001);
        expect_wr(c + 2, 16'h0003);
        expect_wr(c + 3, 16'h0006);
        expect_wr(c + 4, 16'h000C);
        wait_cyc(c + 4);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 5, 16'h0000);
        repeat (2) begin @(posedge clk); #1; end

        // SHIFT right from 8001
        c = cyc;
        bus_write(REG_CTRL, 32'd7);
        expect_wr(c + 1, 16'h8001);
        expect_wr(c + 2, 16'hC000);
        expect_wr(c + 3, 16'h6000);
        expect_wr(c + 4, 16'h3000);
        wait_cyc(c + 4);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 5, 16'h0000);
        repeat (2) begin @(posedge clk); #1; end

        // Rotate wrap: bit 0 -> bit 15 (right) and bit 15 -> bit 0 (left)
        bus_write(REG_PATTERN, 32'h0000_0001);
        c = cyc;
        bus_write(REG_CTRL, 32'd7);
        expect_wr(c + 1, 16'h0001);
        expect_wr(c + 2, 16'h8000);
        wait_cyc(c + 2);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 3, 16'h0000);
        bus_write(REG_PATTERN, 32'h0000_8000);
        c = cyc;
        bus_write(REG_CTRL, 32'd3);
        expect_wr(c + 1, 16'h8000);
        expect_wr(c + 2, 16'h0001);
        wait_cyc(c + 2);
        bus_write(REG_CTRL, 32'd0);
        expect_wr(c + 3, 16'h0000);
        repeat (2) begin @(posedge clk); #1; end

        // Reset mid-BLINK while the OFF write is pending on the output
        bus_write(REG_PERIOD, 32'd3);
        bus_write(REG_PATTERN, 32'h0000_00FF);
        c = cyc;
        bus_write(REG_CTRL, 32'd2);
        expect_wr(c + 1, 16'h00FF);
        wait_cyc(c + 5);
        rst = 1'b1;
        #1;
        check_val("midrst_led_we", 32'(led_we), 32'd0);
        check_val("midrst_led_wdata", 32'(led_wdata), 32'd0);
        read_chk(REG_STATUS, 32'h0, "midrst_status");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        read_chk(REG_STATUS, 32'h0, "postrst_status");
        read_chk(REG_CTRL, 32'h0, "postrst_ctrl");
        read_chk(REG_PATTERN, 32'h0, "postrst_pattern");
        check_val("postrst_led_wdata", 32'(led_wdata), 32'd0);
        c = cyc;
        bus_write(REG_CTRL, 32'd1);
        expect_wr(c + 1, 16'h0000);
        read_chk(REG_STATUS, 32'h0001_0000, "postrst_direct_status");

        repeat (4) begin @(posedge clk); #1; end
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
